// File: rtl/instruction_fetch_pkg.sv
// Shared cpu package: word width, fetch FSM state encoding and the default
// reset PC. Control, Decoder and RegisterFile import the same definitions.
package instruction_fetch_pkg;

    localparam int unsigned WORD_W = 13;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEFAULT_RESET_PC = 13'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        ERROR = 2'd2
    } fetchState_t;

endpackage

// File: rtl/instruction_fetch_timer.sv
// fetch_timer: counts consecutive FETCH cycles that pass without a memory
// completion and flags the cycle in which the count reaches MAX_WAIT.
//   clk     : clock
//   reset   : asynchronous active-low reset
//   clear   : restart the count (takes priority over enable)
//   enable  : one more waiting cycle this clock
//   expired : this waiting cycle is the MAX_WAIT-th one
module fetch_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] count;

    // Count holds the number of waiting cycles already completed, so the
    // current cycle is the MAX_WAIT-th one when count equals MAX_WAIT-1.
    always_comb begin
        expired = enable && (count == LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetches 13-bit instruction words from Main_Memory and
// presents them to the Decoder with a valid/ready handshake. Supports branch
// redirects (squashing an in-flight read) and a sticky memory timeout.
//   clk, reset        : clock, asynchronous active-low reset
//   mem_addr/read/instr : read request to Main_Memory (held until mem_done)
//   mem_data, mem_done  : read data and completion strobe from Main_Memory
//   instr_out, pc_out   : held instruction word and its address
//   instr_valid/ready   : handshake with Decoder/Control
//   branch_taken/target : redirect request from Control
//   fetch_err           : sticky timeout flag; block stops until reset
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter word_t       RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic [WORD_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_instr,
    input  logic [WORD_W-1:0] mem_data,
    input  logic              mem_done,
    output logic [WORD_W-1:0] instr_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] pc_out,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              fetch_err
);

    fetchState_t state, stateNext;
    word_t       pc, instrReg, pcOutReg;
    logic        squash, fetchErr;
    logic        timerClear, timerEnable, timerExpired;

    always_comb begin
        timerEnable = (state == FETCH) && !mem_done;
        timerClear  = (state != FETCH) || mem_done;
    end

    fetch_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) uTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expired(timerExpired)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            FETCH: begin
                if (timerExpired) begin
                    stateNext = ERROR;
                end else if (mem_done && !squash && !branch_taken) begin
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                // A branch also releases the held word (counts as accepted).
                if (branch_taken || instr_ready) begin
                    stateNext = FETCH;
                end
            end
            default: stateNext = ERROR;
        endcase
    end

    // Datapath: PC, instruction register, squash and error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            instrReg <= '0;
            pcOutReg <= '0;
            squash   <= 1'b0;
            fetchErr <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (branch_taken) begin
                        // A redirect coinciding with mem_done discards that
                        // word and the next cycle already fetches the target,
                        // so squash is only needed while the old read is open.
                        pc     <= branch_target;
                        squash <= !mem_done;
                    end else if (mem_done) begin
                        if (squash) begin
                            squash <= 1'b0;
                        end else begin
                            instrReg <= mem_data;
                            pcOutReg <= pc;
                            pc       <= pc + 1'b1;
                        end
                    end
                    if (timerExpired) begin
                        fetchErr <= 1'b1;
                    end
                end
                HOLD: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic; requests are suppressed while reset is held low.
    always_comb begin
        mem_read    = 1'b0;
        mem_instr   = 1'b0;
        instr_valid = 1'b0;
        mem_addr    = pc;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    mem_instr = 1'b1;
                end
                HOLD:    instr_valid = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        instr_out = instrReg;
        pc_out    = pcOutReg;
        fetch_err = fetchErr;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset, memRead, memInstr, memDone, instrValid, instrReady;
    logic        branchTaken, fetchErr;
    logic [12:0] memAddr, memData, instrOut, pcOut, branchTarget;
    int          nChecks = 0;
    int          nFails  = 0;

    instruction_fetch #(
        .RESET_PC(13'h0000),
        .MAX_WAIT(15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (memAddr),
        .mem_read     (memRead),
        .mem_instr    (memInstr),
        .mem_data     (memData),
        .mem_done     (memDone),
        .instr_out    (instrOut),
        .instr_valid  (instrValid),
        .instr_ready  (instrReady),
        .pc_out       (pcOut),
        .branch_taken (branchTaken),
        .branch_target(branchTarget),
        .fetch_err    (fetchErr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset        = 1'b0;
        memDone      = 1'b0;
        memData      = '0;
        instrReady   = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        nChecks++; if (memRead !== 1'b0) begin nFails++; $display("FAIL rst_memRead got %b exp 0", memRead); end
        nChecks++; if (memInstr !== 1'b0) begin nFails++; $display("FAIL rst_memInstr got %b exp 0", memInstr); end
        nChecks++; if (memAddr !== 13'h0000) begin nFails++; $display("FAIL rst_memAddr got %h exp 0000", memAddr); end
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL rst_instrValid got %b exp 0", instrValid); end
        nChecks++; if (fetchErr !== 1'b0) begin nFails++; $display("FAIL rst_fetchErr got %b exp 0", fetchErr); end
        nChecks++; if (instrOut !== 13'h0000) begin nFails++; $display("FAIL rst_instrOut got %h exp 0000", instrOut); end
        nChecks++; if (pcOut !== 13'h0000) begin nFails++; $display("FAIL rst_pcOut got %h exp 0000", pcOut); end
        // Asynchronous reset mid-hold, then a stale done after release.
        apply_reset();
        memDone = 1'b1; memData = 13'h0555;
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrValid !== 1'b1) begin nFails++; $display("FAIL pre_async_valid got %b exp 1", instrValid); end
        #1 reset = 1'b0;
        #1;
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL async_valid got %b exp 0", instrValid); end
        nChecks++; if (instrOut !== 13'h0000) begin nFails++; $display("FAIL async_instrOut got %h exp 0000", instrOut); end
        nChecks++; if (memRead !== 1'b0) begin nFails++; $display("FAIL async_memRead got %b exp 0", memRead); end
        @(posedge clk);
        #1 reset = 1'b1;
        memDone = 1'b1; memData = 13'h0666;
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrOut !== 13'h0666) begin nFails++; $display("FAIL stale_instrOut got %h exp 0666", instrOut); end
        nChecks++; if (pcOut !== 13'h0000) begin nFails++; $display("FAIL stale_pcOut got %h exp 0000", pcOut); end
    endtask

    task automatic test_first_fetch;
        apply_reset();
        memDone = 1'b1; memData = 13'h0ABC; instrReady = 1'b1;
        @(negedge clk);
        nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL ff_memRead got %b exp 1", memRead); end
        nChecks++; if (memInstr !== 1'b1) begin nFails++; $display("FAIL ff_memInstr got %b exp 1", memInstr); end
        nChecks++; if (memAddr !== 13'h0000) begin nFails++; $display("FAIL ff_memAddr got %h exp 0000", memAddr); end
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL ff_valid0 got %b exp 0", instrValid); end
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrValid !== 1'b1) begin nFails++; $display("FAIL ff_valid got %b exp 1", instrValid); end
        nChecks++; if (instrOut !== 13'h0ABC) begin nFails++; $display("FAIL ff_instrOut got %h exp 0abc", instrOut); end
        nChecks++; if (pcOut !== 13'h0000) begin nFails++; $display("FAIL ff_pcOut got %h exp 0000", pcOut); end
        nChecks++; if (memRead !== 1'b0) begin nFails++; $display("FAIL ff_holdRead got %b exp 0", memRead); end
        tick();
        instrReady = 1'b0;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0001) begin nFails++; $display("FAIL ff_nextAddr got %h exp 0001", memAddr); end
        nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL ff_nextRead got %b exp 1", memRead); end
    endtask

    task automatic test_back_pressure;
        apply_reset();
        memDone = 1'b1; memData = 13'h1234;
        tick();
        for (int i = 0; i < 5; i++) begin
            memDone = (i == 2);
            memData = (i == 2) ? 13'h1FFF : 13'h0000;
            @(negedge clk);
            nChecks++; if (instrOut !== 13'h1234) begin nFails++; $display("FAIL bp_instrOut[%0d] got %h exp 1234", i, instrOut); end
            nChecks++; if (pcOut !== 13'h0000) begin nFails++; $display("FAIL bp_pcOut[%0d] got %h exp 0000", i, pcOut); end
            nChecks++; if (memRead !== 1'b0) begin nFails++; $display("FAIL bp_memRead[%0d] got %b exp 0", i, memRead); end
            nChecks++; if (instrValid !== 1'b1) begin nFails++; $display("FAIL bp_valid[%0d] got %b exp 1", i, instrValid); end
            tick();
        end
        memDone = 1'b0; instrReady = 1'b1;
        tick();
        instrReady = 1'b0;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0001) begin nFails++; $display("FAIL bp_nextAddr got %h exp 0001", memAddr); end
        nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL bp_nextRead got %b exp 1", memRead); end
    endtask

    task automatic test_wrap;
        apply_reset();
        memDone = 1'b1; memData = 13'h0001;
        tick();
        memDone = 1'b0; branchTaken = 1'b1; branchTarget = 13'h1FFF;
        tick();
        branchTaken = 1'b0;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h1FFF) begin nFails++; $display("FAIL wr_branchAddr got %h exp 1fff", memAddr); end
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL wr_validDrop got %b exp 0", instrValid); end
        memDone = 1'b1; memData = 13'h0777;
        tick();
        memDone = 1'b0; instrReady = 1'b1;
        @(negedge clk);
        nChecks++; if (pcOut !== 13'h1FFF) begin nFails++; $display("FAIL wr_pcOut got %h exp 1fff", pcOut); end
        nChecks++; if (instrOut !== 13'h0777) begin nFails++; $display("FAIL wr_instrOut got %h exp 0777", instrOut); end
        tick();
        instrReady = 1'b0;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0000) begin nFails++; $display("FAIL wr_wrapAddr got %h exp 0000", memAddr); end
    endtask

    task automatic test_squash;
        apply_reset();
        memDone = 1'b1; memData = 13'h0005;
        tick();
        memDone = 1'b0; branchTaken = 1'b1; branchTarget = 13'h0005;
        tick();
        branchTarget = 13'h0040;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0005) begin nFails++; $display("FAIL sq_addr5 got %h exp 0005", memAddr); end
        tick();
        branchTaken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL sq_heldRead[%0d] got %b exp 1", i, memRead); end
            nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL sq_valid[%0d] got %b exp 0", i, instrValid); end
            tick();
        end
        memDone = 1'b1; memData = 13'h1BAD;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0040) begin nFails++; $display("FAIL sq_addrAtDone got %h exp 0040", memAddr); end
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL sq_discard got %b exp 0", instrValid); end
        nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL sq_reissue got %b exp 1", memRead); end
        nChecks++; if (memAddr !== 13'h0040) begin nFails++; $display("FAIL sq_newAddr got %h exp 0040", memAddr); end
        memDone = 1'b1; memData = 13'h0123;
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrOut !== 13'h0123) begin nFails++; $display("FAIL sq_instrOut got %h exp 0123", instrOut); end
        nChecks++; if (pcOut !== 13'h0040) begin nFails++; $display("FAIL sq_pcOut got %h exp 0040", pcOut); end
    endtask

    task automatic test_branch_vs_ready;
        apply_reset();
        memDone = 1'b1; memData = 13'h0AAA;
        tick();
        memDone = 1'b0; branchTaken = 1'b1; branchTarget = 13'h0100; instrReady = 1'b1;
        tick();
        branchTaken = 1'b0; instrReady = 1'b0;
        @(negedge clk);
        nChecks++; if (memAddr !== 13'h0100) begin nFails++; $display("FAIL bvr_addr got %h exp 0100", memAddr); end
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL bvr_valid got %b exp 0", instrValid); end
        nChecks++; if (memRead !== 1'b1) begin nFails++; $display("FAIL bvr_read got %b exp 1", memRead); end
    endtask

    task automatic test_branch_with_done;
        apply_reset();
        memDone = 1'b1; memData = 13'h0BEE; branchTaken = 1'b1; branchTarget = 13'h0200;
        tick();
        memDone = 1'b0; branchTaken = 1'b0;
        @(negedge clk);
        nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL bwd_valid got %b exp 0", instrValid); end
        nChecks++; if (memAddr !== 13'h0200) begin nFails++; $display("FAIL bwd_addr got %h exp 0200", memAddr); end
        memDone = 1'b1; memData = 13'h0321;
        tick();
        memDone = 1'b0;
        @(negedge clk);
        nChecks++; if (instrOut !== 13'h0321) begin nFails++; $display("FAIL bwd_instrOut got %h exp 0321", instrOut); end
        nChecks++; if (pcOut !== 13'h0200) begin nFails++; $display("FAIL bwd_pcOut got %h exp 0200", pcOut); end
    endtask

    task automatic test_timeout;
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            nChecks++; if (fetchErr !== 1'b0 || memRead !== 1'b1) begin
                nFails++; $display("FAIL to_wait[%0d] got err=%b read=%b exp err=0 read=1", i, fetchErr, memRead);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            memDone = 1'b1; memData = 13'h0999; branchTaken = 1'b1; branchTarget = 13'h0300;
            @(negedge clk);
            nChecks++; if (fetchErr !== 1'b1) begin nFails++; $display("FAIL to_err[%0d] got %b exp 1", i, fetchErr); end
            nChecks++; if (memRead !== 1'b0 || memInstr !== 1'b0) begin nFails++; $display("FAIL to_read[%0d] got %b exp 0", i, memRead); end
            nChecks++; if (instrValid !== 1'b0) begin nFails++; $display("FAIL to_valid[%0d] got %b exp 0", i, instrValid); end
            tick();
        end
        memDone = 1'b0; branchTaken = 1'b0;
        reset = 1'b0;
        #1;
        nChecks++; if (fetchErr !== 1'b0) begin nFails++; $display("FAIL to_clear got %b exp 0", fetchErr); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset        = 1'b0;
        memDone      = 1'b0;
        memData      = '0;
        instrReady   = 1'b0;
        branchTaken  = 1'b0;
        branchTarget = '0;
        test_reset();
        test_first_fetch();
        test_back_pressure();
        test_wrap();
        test_squash();
        test_branch_vs_ready();
        test_branch_with_done();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 13'h0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter MAX_WAIT, default 15, giving the maximum cycles a fetch waits for mem_done.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port mem_addr, output, 13 bits: word address to Main_Memory.
REQ-006 The block SHALL have port mem_read, output, 1 bit: read request to Main_Memory, level-held until mem_done.
REQ-007 The block SHALL have port mem_instr, output, 1 bit: instruction-space select to Main_Memory; 1 whenever mem_read is 1.
REQ-008 The block SHALL have port mem_data, input, 13 bits: read data from Main_Memory, valid when mem_done=1.
REQ-009 The block SHALL have port mem_done, input, 1 bit: Main_Memory completion strobe.
REQ-010 The block SHALL have port instr_out, output, 13 bits: fetched instruction word to the Decoder.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr_out holds a valid instruction.
REQ-012 The block SHALL have port instr_ready, input, 1 bit: Decoder/Control accepts instr_out this cycle.
REQ-013 The block SHALL have port pc_out, output, 13 bits: address of the instruction on instr_out.
REQ-014 The block SHALL have port branch_taken, input, 1 bit: redirect request from Control.
REQ-015 The block SHALL have port branch_target, input, 13 bits: redirect address, sampled when branch_taken=1.
REQ-016 The block SHALL have port fetch_err, output, 1 bit: sticky memory-timeout flag.

Function
REQ-017 The FSM SHALL have states FETCH, HOLD, ERROR.
REQ-018 In FETCH, the block SHALL drive mem_read=1, mem_instr=1, mem_addr=pc, instr_valid=0.
REQ-019 In FETCH with mem_done=1 and no pending squash, the block SHALL capture mem_data into IR and pc into pc_out, set pc to pc+1, and enter HOLD.
REQ-020 The PC increment SHALL be 13-bit modulo: 13'h1FFF+1 = 13'h0000.
REQ-021 In HOLD, the block SHALL drive instr_valid=1 and mem_read=0, holding instr_out and pc_out stable until a handshake.
REQ-022 In HOLD with instr_ready=1, the block SHALL enter FETCH on the next cycle, giving a minimum of 2 cycles per instruction when mem_done arrives in the first FETCH cycle.
REQ-023 A branch_taken in HOLD SHALL load pc with branch_target, drop instr_valid the next cycle, and enter FETCH; when simultaneous with instr_ready, the branch SHALL win and the held instruction counts as accepted.
REQ-024 A branch_taken in FETCH SHALL load pc with branch_target and set squash; mem_read SHALL stay high until mem_done.
REQ-025 When mem_done arrives with squash set, the returned data SHALL be discarded, squash cleared, and a new fetch issued at the redirected pc without leaving FETCH.
REQ-026 A branch_taken coincident with mem_done in FETCH SHALL discard that data and redirect.
REQ-027 A wait counter SHALL count FETCH cycles without mem_done; when it reaches MAX_WAIT, the block SHALL enter ERROR and set fetch_err=1.
REQ-028 ERROR SHALL be terminal until reset, with mem_read=0, instr_valid=0, and branch_taken ignored.
REQ-029 A mem_done received outside FETCH SHALL be ignored.

Reset
REQ-030 On reset=0, the block SHALL asynchronously set state=FETCH, pc=RESET_PC, IR=0, pc_out=0, squash=0, wait counter=0, and fetch_err=0.
REQ-031 While reset=0, outputs SHALL be mem_read=0, mem_instr=0, mem_addr=RESET_PC, and instr_valid=0.
REQ-032 The first mem_read SHALL assert in the first clock cycle after reset deasserts.
REQ-033 A reset asserted mid-fetch SHALL abandon the request; a later stale mem_done SHALL be handled as a normal completion of the new fetch.

Structure
REQ-034 WORD_W=13, the fetch state enum, and RESET_PC's default SHALL live in the shared cpu package used by Control, Decoder, and RegisterFile.
REQ-035 The wait counter with its MAX_WAIT compare SHALL be the sub-module fetch_timer, with ports clk, reset, clear, enable, and expired.

Verification
REQ-036 Scenario (reset and first fetch): memory word0=13'h0ABC with 1-cycle done and instr_ready=1 -> mem_read rises the cycle after reset; instr_out=13'h0ABC, pc_out=0, and instr_valid=1 one cycle after done.
REQ-037 Scenario (back-pressure): instr_ready=0 for 5 cycles -> instr_out and pc_out stable and mem_read=0 throughout; next fetch is at pc=1.
REQ-038 Scenario (wrap-around): branch_target=13'h1FFF, then a completed fetch -> next mem_addr=13'h0000.
REQ-039 Scenario (squash): branch_taken with target 13'h0040 during FETCH at addr 5, done 3 cycles later -> data from addr 5 never presented; next mem_addr=13'h0040.
REQ-040 Scenario (branch vs ready): branch_taken and instr_ready in the same HOLD cycle -> next mem_addr=branch_target, not pc+1.
REQ-041 Scenario (timeout): mem_done held at 0 -> fetch_err=1 after 15 FETCH cycles and mem_read=0; both remain until reset.
